// File: rtl/xbar_serial_tx.sv
// Per-port serial frame transmitter: sync header followed by SLOTS words, MSB-first,
// fed by a 2-entry valid/ready FIFO. Exports header_present, running_slot and underrun.
module xbar_serial_tx #(
  parameter int              SLOTS  = 8,
  parameter int              DATA_W = 8,
  parameter int              HDR_W  = 8,
  parameter logic [HDR_W-1:0] SYNC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     serial_out,
  output logic                     header_present,
  output logic [$clog2(SLOTS)-1:0] running_slot,
  output logic                     underrun
);

  localparam int SW   = $clog2(SLOTS);
  localparam int SHW  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNTW = (SHW > 1) ? $clog2(SHW) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_SLOT = 2'd2;

  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] HDR_LAST  = CNTW'(HDR_W - 1);
  localparam logic [CNTW-1:0] DATA_LAST = CNTW'(DATA_W - 1);
  localparam logic [SW-1:0]   SLOT_ONE  = SW'(1);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SLOTS - 1);
  // Header and data are left-aligned so the shift register MSB is always the line bit.
  localparam logic [SHW-1:0]  SYNC_AL   = SHW'(SYNC) << (SHW - HDR_W);

  logic [1:0]        state_q, state_d;
  logic [SHW-1:0]    shreg_q, shreg_d, shreg_n_s;
  logic [CNTW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]     slot_cnt_q, slot_cnt_d;
  logic              hdr_q, hdr_d;
  logic [SW-1:0]     rslot_q, rslot_d;
  logic              und_q, und_d;
  logic              load_s;

  logic [DATA_W-1:0] fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;
  logic              push_s, pop_s, empty_s, full_s;

  assign empty_s = (count_q == 2'd0);
  assign full_s  = (count_q == 2'd2);
  assign push_s  = tx_valid && !full_s;
  assign pop_s   = load_s && !empty_s;

  assign tx_ready       = !full_s;
  assign serial_out     = shreg_q[SHW-1];
  assign header_present = hdr_q;
  assign running_slot   = rslot_q;
  assign underrun       = und_q;

  always_comb begin
    state_d    = state_q;
    shreg_n_s  = shreg_q << 1;
    bit_cnt_d  = bit_cnt_q + CNT_ONE;
    slot_cnt_d = slot_cnt_q;
    hdr_d      = hdr_q;
    rslot_d    = rslot_q;
    load_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        rslot_d   = '0;
        if (enable) begin
          state_d   = S_HDR;
          shreg_n_s = SYNC_AL;
          hdr_d     = 1'b1;
        end else begin
          shreg_n_s = '0;
          hdr_d     = 1'b0;
        end
      end
      S_HDR: begin
        if (bit_cnt_q == HDR_LAST) begin
          state_d    = S_SLOT;
          bit_cnt_d  = '0;
          slot_cnt_d = '0;
          hdr_d      = 1'b0;
          rslot_d    = '0;
          load_s     = 1'b1;
        end else begin
          hdr_d = 1'b1;
        end
      end
      S_SLOT: begin
        if (bit_cnt_q == DATA_LAST) begin
          bit_cnt_d = '0;
          if (slot_cnt_q != SLOT_LAST) begin
            slot_cnt_d = slot_cnt_q + SLOT_ONE;
            rslot_d    = slot_cnt_q + SLOT_ONE;
            load_s     = 1'b1;
          end else if (enable) begin
            // Back-to-back frame: next header starts without an idle bit.
            state_d    = S_HDR;
            shreg_n_s  = SYNC_AL;
            slot_cnt_d = '0;
            rslot_d    = '0;
            hdr_d      = 1'b1;
          end else begin
            state_d    = S_IDLE;
            shreg_n_s  = '0;
            slot_cnt_d = '0;
            rslot_d    = '0;
          end
        end else begin
          rslot_d = slot_cnt_q;
        end
      end
      default: begin
        state_d    = S_IDLE;
        shreg_n_s  = '0;
        bit_cnt_d  = '0;
        slot_cnt_d = '0;
        hdr_d      = 1'b0;
        rslot_d    = '0;
      end
    endcase
  end

  always_comb begin
    if (load_s) begin
      shreg_d = empty_s ? '0 : (SHW'(fifo_q[rd_ptr_q]) << (SHW - DATA_W));
      und_d   = empty_s;
    end else begin
      shreg_d = shreg_n_s;
      und_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
      hdr_q      <= 1'b0;
      rslot_q    <= '0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      hdr_q      <= hdr_d;
      rslot_q    <= rslot_d;
      und_q      <= und_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= tx_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_serial_tx.sv
// Randomised bench for xbar_serial_tx: a frame-position model predicts every output each cycle.
module tb_xbar_serial_tx;

  localparam int SLOTS  = 8;
  localparam int DATA_W = 8;
  localparam int HDR_W  = 8;
  localparam int FRAME  = HDR_W + SLOTS * DATA_W;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       serial_out;
  logic       header_present;
  logic [2:0] running_slot;
  logic       underrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xbar_serial_tx #(.SLOTS(SLOTS), .DATA_W(DATA_W), .HDR_W(HDR_W), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .serial_out(serial_out), .header_present(header_present),
    .running_slot(running_slot), .underrun(underrun)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the current frame, the word being sent, and the FIFO as a queue.
  logic [7:0] mq[$];
  bit         m_idle = 1'b1;
  int         m_pos  = 0;
  logic [7:0] m_word = 8'h00;
  bit         m_und  = 1'b0;
  bit         m_push;
  logic [7:0] m_pval;
  bit         m_en;
  logic [7:0] sync_v = 8'hA5;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_idle = 1'b1; m_pos = 0; m_word = 8'h00; m_und = 1'b0;
    end else begin
      m_push = tx_valid && (mq.size() < 2);
      m_pval = tx_data;
      m_en   = enable;
      if (m_idle) begin
        if (m_en) begin m_idle = 1'b0; m_pos = 0; end
      end else if (m_pos == FRAME - 1) begin
        if (m_en) m_pos = 0; else m_idle = 1'b1;
      end else begin
        m_pos++;
      end
      if (!m_idle && m_pos >= HDR_W && ((m_pos - HDR_W) % DATA_W) == 0) begin
        if (mq.size() > 0) begin m_word = mq.pop_front(); m_und = 1'b0; end
        else begin m_word = 8'h00; m_und = 1'b1; end
      end
      if (m_push) mq.push_back(m_pval);
    end
  end

  int e_so, e_hp, e_rs, e_un, off;
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0) begin
      if (m_idle) begin
        e_so = 0; e_hp = 0; e_rs = 0; e_un = 0;
      end else if (m_pos < HDR_W) begin
        e_so = int'(sync_v[HDR_W-1-m_pos]); e_hp = 1; e_rs = 0; e_un = 0;
      end else begin
        off  = m_pos - HDR_W;
        e_so = int'(m_word[DATA_W-1-(off % DATA_W)]);
        e_hp = 0;
        e_rs = off / DATA_W;
        e_un = (m_und && (off % DATA_W) == 0) ? 1 : 0;
      end
      check("serial_out", int'(serial_out), e_so);
      check("header_present", int'(header_present), e_hp);
      check("running_slot", int'(running_slot), e_rs);
      check("underrun", int'(underrun), e_un);
      check("tx_ready", int'(tx_ready), (mq.size() < 2) ? 1 : 0);
    end
  end

  // Producer: holds its head word until a handshake completes.
  logic [7:0] prod_q[$];
  int         valid_pct = 100;
  bit         rdy_s = 1'b0;

  task automatic cycle();
    @(negedge clk);
    if (!rst && tx_valid && rdy_s) void'(prod_q.pop_front());
    rdy_s = tx_ready;
    if (!rst && prod_q.size() > 0 && ($urandom_range(99) < valid_pct)) begin
      tx_valid = 1'b1; tx_data = prod_q[0];
    end else begin
      tx_valid = 1'b0; tx_data = 8'($urandom);
    end
  endtask

  task automatic run_frame(output logic [FRAME-1:0] bits, output int nund);
    cycle();
    enable = 1'b1;
    nund = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      enable = 1'b0;
      bits[FRAME-1-i] = serial_out;
      nund += int'(underrun);
      if (i == 0) check("hp_first_bit", int'(header_present), 1);
      if (i == HDR_W) check("hp_slot0", int'(header_present), 0);
      if (i == FRAME - 1) check("last_slot_idx", int'(running_slot), SLOTS - 1);
    end
  endtask

  task automatic do_reset();
    cycle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    prod_q.delete();
  endtask

  logic [FRAME-1:0] bits;
  int               nund;
  logic [7:0]       exp1 [9];
  logic [7:0]       w [3];

  initial begin
    rst = 1'b1; enable = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) cycle();
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_serial_out", int'(serial_out), 0);
    check("rst_running_slot", int'(running_slot), 0);
    rst = 1'b0;

    // Test 1: preload two words, stream the rest, one full frame.
    exp1 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int k = 1; k < 9; k++) prod_q.push_back(exp1[k]);
    repeat (4) cycle();
    check("preload_full", int'(tx_ready), 0);
    check("preload_accepted", prod_q.size(), 6);
    run_frame(bits, nund);
    for (int k = 0; k < 9; k++) check("t1_frame_byte", int'(bits[FRAME-1-8*k -: 8]), int'(exp1[k]));
    check("t1_underruns", nund, 0);
    cycle();
    check("t1_idle_hp", int'(header_present), 0);
    check("t1_idle_so", int'(serial_out), 0);

    // Test 2: empty FIFO -> header then zeros, one underrun per slot.
    run_frame(bits, nund);
    check("t2_header", int'(bits[FRAME-1 -: 8]), 32'hA5);
    check("t2_zero_lo", int'(bits[31:0]), 0);
    check("t2_zero_hi", int'(bits[63:32]), 0);
    check("t2_underruns", nund, 8);

    // Tests 3 and 6: back-to-back frames, enable dropped in slot 3 of frame 2.
    valid_pct = 70;
    for (int k = 0; k < 24; k++) prod_q.push_back(8'($urandom));
    cycle();
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      cycle();
      if (i == FRAME) begin
        check("t3_hdr2_hp", int'(header_present), 1);
        check("t3_hdr2_so", int'(serial_out), 1);
        check("t3_hdr2_slot", int'(running_slot), 0);
      end
      if (i == FRAME + HDR_W + 3 * DATA_W + 2) enable = 1'b0;
      if (i >= 2 * FRAME) check("t6_idle_hp", int'(header_present), 0);
    end

    // Test 4: three pushes without enable; third waits for the first slot load.
    do_reset();
    valid_pct = 100;
    for (int k = 0; k < 3; k++) begin w[k] = 8'($urandom); prod_q.push_back(w[k]); end
    repeat (5) cycle();
    check("t4_full", int'(tx_ready), 0);
    check("t4_held", prod_q.size(), 1);
    run_frame(bits, nund);
    for (int k = 0; k < 3; k++) check("t4_word", int'(bits[FRAME-HDR_W-1-8*k -: 8]), int'(w[k]));
    check("t4_underruns", nund, 5);
    check("t4_drained", prod_q.size(), 0);

    // Test 5: reset mid-frame.
    for (int k = 0; k < 8; k++) prod_q.push_back(8'($urandom));
    cycle();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      enable = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("t5_so", int'(serial_out), 0);
    check("t5_hp", int'(header_present), 0);
    check("t5_slot", int'(running_slot), 0);
    check("t5_ready", int'(tx_ready), 1);
    cycle();
    rst = 1'b0;
    prod_q.delete();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t5_idle_hp", int'(header_present), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
